// File: rtl/uart_pkg.sv
// Shared types and the rotate-priority pick helper for the UART transmit arbiter.
package uart_pkg;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CLR,
        WAIT_DONE
    } arb_state_t;

    typedef struct packed {
        logic             hit;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // Unused upper requester slots are zero, so wrapping modulo MAX_REQ gives the
    // same order as wrapping modulo the real requester count.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                         input logic [PTR_W-1:0]   ptr);
        rr_pick_t         pick;
        logic [PTR_W-1:0] cand;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (vld[cand]) begin
                pick.hit = 1'b1;
                pick.idx = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority picker: first valid requester at or after ptr.
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         vld,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       hit,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    rr_pick_t w_pick;
    logic     w_unused_idx;

    assign w_pick       = rr_pick(MAX_REQ'(vld), PTR_W'(ptr));
    assign hit          = w_pick.hit;
    assign idx          = w_pick.idx[IDX_W-1:0];
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst locking that shares one UART_tx among NUM_REQ
// byte producers and sequences trmt/tx_done so only one byte is in flight.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic             r_lock_vld;
    logic [7:0]       r_burst_cnt;

    logic             w_rr_hit;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_lock_hit;
    logic             w_launch;
    logic             w_sel_lock;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_ptr_next;
    logic [7:0]       w_burst_next;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .vld (req_vld),
        .ptr (r_rr_ptr),
        .hit (w_rr_hit),
        .idx (w_rr_idx)
    );

    always_comb begin
        // NOTE: every signal is given a value on every path here, so no latch is inferred.
        w_lock_hit = r_lock_vld && req_vld[r_owner] && req_lock[r_owner]
                     && (r_burst_cnt < BURST_MAX);
        w_sel      = w_lock_hit ? r_owner : w_rr_idx;
        w_launch   = (r_state == IDLE) && (w_lock_hit || w_rr_hit);
        w_sel_lock = req_lock[w_sel];
        // A lock hit implies r_burst_cnt < BURST_MAX, so the increment saturates by construction.
        w_burst_next = w_lock_hit ? (r_burst_cnt + 8'd1) : 8'd1;
        w_ptr_next   = w_sel;
        if (!w_sel_lock || (w_burst_next >= BURST_MAX)) begin
            w_ptr_next = (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_lock_vld  <= 1'b0;
            r_burst_cnt <= 8'd0;
            trmt        <= 1'b0;
            req_rdy     <= '0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            gnt_id      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            trmt    <= 1'b0;
            req_rdy <= '0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        tx_data     <= req_data[8*w_sel +: 8];
                        trmt        <= 1'b1;
                        req_rdy     <= NUM_REQ'(1) << w_sel;
                        gnt_id      <= w_sel;
                        busy        <= 1'b1;
                        r_rr_ptr    <= w_ptr_next;
                        r_burst_cnt <= w_burst_next;
                        r_owner     <= w_sel;
                        r_lock_vld  <= w_sel_lock;
                        r_state     <= WAIT_CLR;
                    end else begin
                        r_lock_vld  <= 1'b0;
                    end
                end
                // tx_done may still be high from the previous byte; wait for it to clear.
                WAIT_CLR: begin
                    if (!tx_done) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
